// File: rtl/fft_shift_pp.sv
// FFT-shift reorder buffer: captures one natural-order frame into a ping-pong bank,
// drops the centre gap and replays the kept bins in centred (or bypass) order.
module fft_shift_pp #(
  parameter int DATA_W = 32,
  parameter int N_LOG2 = 13,
  parameter int KEEP   = 8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [N_LOG2-1:0] in_index,
  input  logic              shift_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N_LOG2:0]   out_index,
  output logic              out_sof,
  output logic              out_eof,
  output logic              overflow,
  output logic              sync_err
);

  localparam int N  = 1 << N_LOG2;
  localparam int H  = KEEP / 2;
  localparam int PW = (KEEP > 1) ? $clog2(KEEP) : 1;
  localparam int IW = N_LOG2 + 1;
  localparam logic [PW-1:0] LAST_POS = PW'(KEEP - 1);

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     idx;
    logic              sof;
    logic              eof;
  } bin_t;

  // Bank bookkeeping and write side
  logic [1:0]    full, mode, full_set, full_clr;
  logic          wr_bank, wr_active, rel_bank;
  logic          frame_start, frame_end, bank_free, map_mode, map_ok, wr_en;
  logic [PW-1:0] map_pos;
  int            k_int;

  // Read side and output stage
  rd_state_t     rd_state;
  logic [PW-1:0] rd_pos;
  logic          rd_bank, rd_mode, rd_en, cur_mode;
  logic [IW-1:0] rd_idx;
  logic          rd_pend, pend_bank, pend_sof, pend_eof;
  logic [IW-1:0] pend_idx;
  logic [1:0]    occ_next;
  logic          pop, rel_now, skid_valid;
  bin_t          skid, incoming;

  logic [DATA_W-1:0] bank0 [KEEP];
  logic [DATA_W-1:0] bank1 [KEEP];
  logic [DATA_W-1:0] q0, q1;

  assign k_int       = int'(in_index);
  assign frame_start = in_valid && (in_index == '0);
  assign frame_end   = in_valid && (in_index == '1);
  assign pop         = out_valid && out_ready;
  assign rel_now     = pop && out_eof;
  // A bank whose last bin leaves the output this cycle may be refilled immediately.
  assign bank_free   = !full[wr_bank] || (rel_now && (rel_bank == wr_bank));
  assign map_mode    = frame_start ? shift_en : mode[wr_bank];
  assign wr_en       = in_valid && map_ok && (frame_start ? bank_free : wr_active);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    map_ok  = 1'b0;
    map_pos = '0;
    if (map_mode) begin
      if (k_int < H) begin
        map_ok  = 1'b1;
        map_pos = PW'(k_int + H);
      end else if (k_int >= N - H) begin
        map_ok  = 1'b1;
        map_pos = PW'(k_int - (N - H));
      end
    end else if (k_int < KEEP) begin
      map_ok  = 1'b1;
      map_pos = PW'(k_int);
    end
  end

  assign full_set = (frame_end && wr_active && !frame_start) ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rel_now ? (2'b01 << rel_bank) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      mode      <= '0;
      wr_bank   <= 1'b0;
      wr_active <= 1'b0;
      rel_bank  <= 1'b0;
      overflow  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      full     <= (full | full_set) & ~full_clr;
      sync_err <= frame_start && wr_active;
      if (rel_now) rel_bank <= ~rel_bank;
      if (frame_start) begin
        if (bank_free) begin
          wr_active     <= 1'b1;
          mode[wr_bank] <= shift_en;
        end else begin
          wr_active <= 1'b0;
          overflow  <= 1'b1;
        end
      end else if (frame_end && wr_active) begin
        wr_active <= 1'b0;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  // NOTE: bank storage has no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) bank0[map_pos] <= in_data;
    if (rd_en && !rd_bank) q0 <= bank0[rd_pos];
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_bank) bank1[map_pos] <= in_data;
    if (rd_en && rd_bank) q1 <= bank1[rd_pos];
  end

  // Issue a read only if the bin it returns is sure to find room in head+skid.
  assign occ_next = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend} - {1'b0, pop};
  assign rd_en    = ((rd_state == RD_READ) || full[rd_bank]) && (occ_next < 2'd2);
  assign cur_mode = (rd_state == RD_READ) ? rd_mode : mode[rd_bank];
  assign rd_idx   = cur_mode ? (IW'(rd_pos) - IW'(H)) : IW'(rd_pos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      rd_pos    <= '0;
      rd_bank   <= 1'b0;
      rd_mode   <= 1'b0;
      rd_pend   <= 1'b0;
      pend_bank <= 1'b0;
      pend_idx  <= '0;
      pend_sof  <= 1'b0;
      pend_eof  <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        pend_bank <= rd_bank;
        pend_idx  <= rd_idx;
        pend_sof  <= (rd_pos == '0);
        pend_eof  <= (rd_pos == LAST_POS);
        if (rd_state == RD_IDLE) rd_mode <= mode[rd_bank];
        if (rd_pos == LAST_POS) begin
          // The bank itself is released later, when its last bin is accepted.
          rd_pos   <= '0;
          rd_bank  <= ~rd_bank;
          rd_state <= RD_IDLE;
        end else begin
          rd_pos   <= rd_pos + 1'b1;
          rd_state <= RD_READ;
        end
      end
    end
  end

  assign incoming = {(pend_bank ? q1 : q0), pend_idx, pend_sof, pend_eof};

  // Head register plus one-entry skid absorbs the bin already in flight on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      skid_valid <= 1'b0;
      skid       <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        {out_data, out_index, out_sof, out_eof} <= skid;
        out_valid  <= 1'b1;
        skid_valid <= rd_pend;
        if (rd_pend) skid <= incoming;
      end else begin
        out_valid <= rd_pend;
        if (rd_pend) {out_data, out_index, out_sof, out_eof} <= incoming;
      end
    end else if (rd_pend) begin
      skid       <= incoming;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_shift_pp.sv
// Directed bench for fft_shift_pp with N=16, KEEP=12, 8-bit payload: table-driven
// frame checks plus hand-written overflow, sync-error, stall and reset sequences.
module tb_fft_shift_pp;

  localparam int DATA_W = 8;
  localparam int N_LOG2 = 4;
  localparam int KEEP   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [N_LOG2-1:0] in_index;
  logic              shift_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N_LOG2:0]   out_index;
  logic              out_sof;
  logic              out_eof;
  logic              overflow;
  logic              sync_err;

  fft_shift_pp #(.DATA_W(DATA_W), .N_LOG2(N_LOG2), .KEEP(KEEP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_index(in_index), .shift_en(shift_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [4:0] idx;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [4:0] idx;
    logic       sof;
    logic       eof;
    int         cyc;
  } cap_t;

  exp_t tbl_shift [KEEP];
  exp_t tbl_byp   [KEEP];
  cap_t cap [$];

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  int   sync_cnt = 0;
  int   stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [4:0] prev_idx  = '0;
  bit   rnd_ready = 1'b0;

  // Monitor on the falling edge: captures accepted bins, sync pulses, stall stability.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (out_valid && out_ready) cap.push_back('{out_data, out_index, out_sof, out_eof, cyc});
      if (sync_err) sync_cnt <= sync_cnt + 1;
      if (prev_stall && (out_data !== prev_data || out_index !== prev_idx))
        stall_viol <= stall_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_idx   <= out_index;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // shift_en is driven inverted on k!=0 so that only the k==0 sample may matter.
  task automatic send_frame(input bit shift, input logic [7:0] base, input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) begin
      in_valid = 1'b1;
      in_index = 4'(k);
      in_data  = base + 8'(k);
      shift_en = (k == 0) ? shift : !shift;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget);
    int t;
    t = 0;
    while (cap.size() < n && t < budget) begin
      step();
      t++;
    end
    check("bin_count", cap.size(), n);
  endtask

  task automatic compare_frame(input int start, input bit shift, input logic [7:0] base, input string tag);
    for (int i = 0; i < KEEP; i++) begin
      exp_t e;
      e = shift ? tbl_shift[i] : tbl_byp[i];
      if (start + i < cap.size()) begin
        check($sformatf("%s data[%0d]", tag, i), cap[start+i].data, 8'(e.data + base));
        check($sformatf("%s index[%0d]", tag, i), cap[start+i].idx, e.idx);
        check($sformatf("%s sof[%0d]", tag, i), cap[start+i].sof, e.sof);
        check($sformatf("%s eof[%0d]", tag, i), cap[start+i].eof, e.eof);
      end
    end
  endtask

  initial begin
    int base;
    int lat;
    int s0;

    tbl_shift = '{
      '{8'd10, 5'h1A, 1'b1, 1'b0}, '{8'd11, 5'h1B, 1'b0, 1'b0}, '{8'd12, 5'h1C, 1'b0, 1'b0},
      '{8'd13, 5'h1D, 1'b0, 1'b0}, '{8'd14, 5'h1E, 1'b0, 1'b0}, '{8'd15, 5'h1F, 1'b0, 1'b0},
      '{8'd0,  5'h00, 1'b0, 1'b0}, '{8'd1,  5'h01, 1'b0, 1'b0}, '{8'd2,  5'h02, 1'b0, 1'b0},
      '{8'd3,  5'h03, 1'b0, 1'b0}, '{8'd4,  5'h04, 1'b0, 1'b0}, '{8'd5,  5'h05, 1'b0, 1'b1}
    };
    tbl_byp = '{
      '{8'd0, 5'd0, 1'b1, 1'b0}, '{8'd1, 5'd1, 1'b0, 1'b0}, '{8'd2,  5'd2,  1'b0, 1'b0},
      '{8'd3, 5'd3, 1'b0, 1'b0}, '{8'd4, 5'd4, 1'b0, 1'b0}, '{8'd5,  5'd5,  1'b0, 1'b0},
      '{8'd6, 5'd6, 1'b0, 1'b0}, '{8'd7, 5'd7, 1'b0, 1'b0}, '{8'd8,  5'd8,  1'b0, 1'b0},
      '{8'd9, 5'd9, 1'b0, 1'b0}, '{8'd10, 5'd10, 1'b0, 1'b0}, '{8'd11, 5'd11, 1'b0, 1'b1}
    };

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_index = '0; shift_en = 1'b0; out_ready = 1'b0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_index", out_index, 0);
    check("rst out_sof", out_sof, 0);
    check("rst out_eof", out_eof, 0);
    check("rst overflow", overflow, 0);
    check("rst sync_err", sync_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tail of a frame with no k==0 after reset must be ignored.
    out_ready = 1'b1;
    send_frame(1'b1, 8'h00, 5, 15);
    idle(10);
    check("pre_sof_ignored", cap.size(), 0);

    // Single centred frame, latency and full throughput.
    base = cap.size();
    send_frame(1'b1, 8'h00, 0, 15);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("first_valid_latency", lat, 2);
    wait_caps(base + KEEP, 100);
    compare_frame(base, 1'b1, 8'h00, "shift");
    if (cap.size() >= base + KEEP)
      check("shift_throughput", cap[base+KEEP-1].cyc - cap[base].cyc, KEEP - 1);
    idle(5);
    check("shift_no_extra", cap.size(), base + KEEP);

    // Bypass frame: bins 12..15 never appear.
    base = cap.size();
    send_frame(1'b0, 8'h00, 0, 15);
    wait_caps(base + KEEP, 100);
    compare_frame(base, 1'b0, 8'h00, "bypass");
    idle(5);
    check("bypass_no_extra", cap.size(), base + KEEP);

    // Three frames into a stalled output: third is dropped.
    out_ready = 1'b0;
    base = cap.size();
    send_frame(1'b1, 8'h10, 0, 15);
    send_frame(1'b1, 8'h20, 0, 15);
    send_frame(1'b1, 8'h30, 0, 15);
    idle(4);
    check("ovf overflow", overflow, 1);
    check("ovf out_valid", out_valid, 1);
    check("ovf stall data", out_data, 8'h1A);
    check("ovf stall sof", out_sof, 1);
    idle(5);
    check("ovf stall data held", out_data, 8'h1A);
    out_ready = 1'b1;
    wait_caps(base + 2*KEEP, 200);
    compare_frame(base, 1'b1, 8'h10, "ovf f1");
    compare_frame(base + KEEP, 1'b1, 8'h20, "ovf f2");
    if (cap.size() >= base + 2*KEEP)
      check("ovf no_gap", cap[base+2*KEEP-1].cyc - cap[base].cyc, 2*KEEP - 1);
    idle(20);
    check("ovf frame3_absent", cap.size(), base + 2*KEEP);

    // Early restart: k=0..7 then a full frame.
    base = cap.size();
    s0 = sync_cnt;
    send_frame(1'b1, 8'h40, 0, 7);
    send_frame(1'b1, 8'h80, 0, 15);
    wait_caps(base + KEEP, 100);
    check("sync_err pulses", sync_cnt - s0, 1);
    compare_frame(base, 1'b1, 8'h80, "sync");
    idle(20);
    check("sync single_frame", cap.size(), base + KEEP);

    // Random backpressure with a stream of mixed-mode frames.
    base = cap.size();
    rnd_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_frame((f % 2) == 0, 8'(16 + 32*f), 0, 15);
      idle(16);
    end
    wait_caps(base + 4*KEEP, 400);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++)
      compare_frame(base + f*KEEP, (f % 2) == 0, 8'(16 + 32*f), $sformatf("rand f%0d", f));
    check("stall_stable", stall_viol, 0);

    // Reset in the middle of an output frame.
    base = cap.size();
    send_frame(1'b1, 8'hA0, 0, 15);
    wait_caps(base + 5, 100);
    rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst out_index", out_index, 0);
    check("midrst out_sof", out_sof, 0);
    check("midrst overflow", overflow, 0);
    check("midrst sync_err", sync_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(30);
    check("midrst no_output", cap.size(), base + 5);
    send_frame(1'b1, 8'hB0, 0, 15);
    wait_caps(base + 5 + KEEP, 100);
    compare_frame(base + 5, 1'b1, 8'hB0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_shift_pp.md
Name: fft_shift_pp

Overview:
- Parametrised FFT-shift reorder buffer for the spectrum datapath. It sits between the FFT/power stage and the downstream detector/packetiser.
- It accepts one natural-order FFT frame of 2^N_LOG2 bins and discards the centre gap bins. It then emits the KEEP remaining bins in centred order (most negative frequency first) with a signed frequency index.
- Ping-pong banks let a new frame be written while the previous one drains. Output uses a valid/ready handshake. A per-frame bypass mode and frame-sync/overflow error reporting are included.

Parameters:
- DATA_W, 32, bin payload width (power or packed I/Q).
- N_LOG2, 13, log2 of FFT size; N = 2^N_LOG2.
- KEEP, 8000, bins retained per frame; must be even and <= N. H = KEEP/2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  bin strobe; no backpressure
- in_data  in  DATA_W  bin payload
- in_index  in  N_LOG2  natural FFT bin index k
- shift_en  in  1  1 = centred order, 0 = bypass (natural order, bins 0..KEEP-1); sampled with k==0
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  reordered payload
- out_index  out  N_LOG2+1  signed frequency index (shift) or unsigned k (bypass)
- out_sof  out  1  first bin of output frame
- out_eof  out  1  last bin of output frame
- overflow  out  1  sticky; a frame was dropped
- sync_err  out  1  one-cycle pulse; frame aborted by early k==0

Behaviour:
- Reset: all outputs 0. Both banks empty, wr_bank=0, read FSM IDLE. The async reset takes effect immediately. Any frame in flight mid-operation is discarded, and no partial output follows reset release.
- Write address mapping when shift_en=1, for each accepted bin:
  - k<H → position k+H
  - k>=N-H → position k-(N-H)
  - otherwise the bin is discarded (not written)
- Write address mapping when shift_en=0 (bypass): k<KEEP → position k; else discarded.
- Each bank is KEEP x DATA_W, inferred RAM with 1-cycle read latency.
- Frame start: in_valid with k==0. This latches shift_en into the bank's mode bit and starts the write if the target bank is empty.
- Frame end: in_valid with k==N-1. This marks the bank full and toggles wr_bank.
- Dropped frames: if the bank at wr_bank is still full (unread) at frame start, the whole frame is dropped. overflow sets (sticky until rst) and writes are suppressed until the next k==0 that finds an empty bank.
- Early restart: k==0 arriving while a write frame is in progress (previous k != N-1) pulses sync_err for one cycle, abandons the partial frame (bank stays empty) and restarts at the new frame. Bins before the first k==0 after reset are ignored.
- Read FSM has two states, IDLE and READ.
  - IDLE→READ when bank rd_bank is full.
  - READ walks positions p=0..KEEP-1, advancing p only when the output register is empty or out_valid&&out_ready.
  - After p=KEEP-1 is accepted, the FSM marks the bank empty, toggles rd_bank and returns to IDLE. It may go straight back to READ if the other bank is already full (no idle cycle required).
- Output stage: registered with a one-entry skid so out_data/out_index hold stable while out_valid&&!out_ready. Full throughput is one bin per cycle when out_ready=1.
- out_index:
  - shift mode: p-H as two's complement, range -H..H-1.
  - bypass: p, zero-extended.
- out_sof is asserted with p=0; out_eof with p=KEEP-1.
- Latency: first out_valid is asserted 2 cycles after the clock edge that accepts k==N-1, when the read side is idle.
- Simultaneous events: a bank full-marking and a read release in the same cycle are both honoured. A write into a bank released that same cycle is legal. A dropped frame never corrupts the bank being read.

Test Plan (N_LOG2=4, KEEP=12, H=6, DATA_W=8):
- Single frame, shift_en=1, in_data=k, k=0..15 back-to-back, out_ready=1 → out_data 10..15,0..5. out_index -6..5. out_sof on the first bin, out_eof on the last. First out_valid 2 cycles after k=15.
- Same frame, shift_en=0 → out_data 0..11, out_index 0..11. Bins 12..15 are never output.
- Three back-to-back frames, out_ready=0 throughout → frames 1 and 2 fill both banks. Frame 3 is dropped and overflow=1. Then raising out_ready outputs frame 1 followed by frame 2 with no gap and no frame-3 data.
- k=0..7 then k=0..15 → one-cycle sync_err on the second k=0. Exactly one output frame results, and it contains the second frame's data.
- Random out_ready toggling with continuous frames → no lost, duplicated or reordered bins. Data is stable while stalled.
- Assert rst mid-output (after 5 bins) → outputs go to 0 immediately. After release, no output until a new complete frame is received.
